// File: rtl/ue14500_sequencer.sv
// Program sequencer for the UE14500 1-bit ICU: drives the program address, latches operands, handles call/return/loop count.
// Latency: ADDR/SP/PASSES/flags update one cycle after the ICU flag pulse; all outputs are registered.
// Backpressure: RUN=0 (or HALTED=1) freezes all state and drops flag pulses; optional FLF halt via UE14500_SEQ_FLF_HALT_EN.
module ue14500_sequencer #(
   parameter int ADDR_W      = 8,
   parameter int STACK_DEPTH = 4,
   localparam int SP_W       = $clog2(STACK_DEPTH + 1)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_run,
   input  logic              i_jmp,
   input  logic              i_rtn,
   input  logic              i_fl0,
   input  logic              i_flf,
   input  logic [ADDR_W-1:0] i_target,
   output logic [ADDR_W-1:0] o_addr,
   output logic [SP_W-1:0]   o_sp,
   output logic [7:0]        o_passes,
   output logic              o_ovf,
   output logic              o_unf,
   output logic              o_halted
);

   // Stack index width; a single-entry stack still needs one index bit.
   localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W-1:0] r_opnd;
   logic [SP_W-1:0]   r_sp;
   logic [7:0]        r_passes;
   logic              r_ovf;
   logic              r_unf;
   logic [ADDR_W-1:0] r_stack [STACK_DEPTH];

   logic [ADDR_W-1:0] w_addr_nxt;
   logic [ADDR_W-1:0] w_opnd_nxt;
   logic [SP_W-1:0]   w_sp_nxt;
   logic [7:0]        w_passes_nxt;
   logic              w_ovf_nxt;
   logic              w_unf_nxt;
   logic              w_push;
   logic              w_adv;
   logic              w_halted;
   logic [IDX_W-1:0]  w_wr_idx;
   logic [IDX_W-1:0]  w_rd_idx;

   assign w_wr_idx = r_sp[IDX_W-1:0];
   assign w_rd_idx = r_sp[IDX_W-1:0] - IDX_W'(1);

`ifdef UE14500_SEQ_FLF_HALT_EN
   logic r_halted;

   // Halt latch: FLF stops the sequencer after this cycle's advance; only reset releases it.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_halted <= 1'b0;
      end else if (w_adv && i_flf) begin
         r_halted <= 1'b1;
      end
   end

   assign w_halted = r_halted;
`else
   // FLF has no effect in this build; keep the port consumed.
   logic w_unused;
   assign w_unused = i_flf;
   assign w_halted = 1'b0;
`endif

   // Flag pulses are honoured only while running and not halted.
   assign w_adv = i_run & ~w_halted;

   // Next-state: one address action per cycle, JMP over RTN over sequential step.
   always_comb begin
      w_addr_nxt   = r_addr;
      w_opnd_nxt   = r_opnd;
      w_sp_nxt     = r_sp;
      w_passes_nxt = r_passes;
      w_ovf_nxt    = r_ovf;
      w_unf_nxt    = r_unf;
      w_push       = 1'b0;
      if (w_adv) begin
         w_opnd_nxt = i_target;
         if (i_fl0) begin
            w_passes_nxt = r_passes + 8'd1;
         end
         if (i_jmp) begin
            // The jump is taken even when the return address cannot be saved.
            if (r_sp < SP_W'(STACK_DEPTH)) begin
               w_push   = 1'b1;
               w_sp_nxt = r_sp + SP_W'(1);
            end else begin
               w_ovf_nxt = 1'b1;
            end
            w_addr_nxt = r_opnd;
         end else if (i_rtn) begin
            if (r_sp != '0) begin
               w_addr_nxt = r_stack[w_rd_idx];
               w_sp_nxt   = r_sp - SP_W'(1);
            end else begin
               w_unf_nxt  = 1'b1;
               w_addr_nxt = r_addr + ADDR_W'(1);
            end
         end else begin
            w_addr_nxt = r_addr + ADDR_W'(1);
         end
      end
   end

   // Architectural state registers with synchronous reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_addr   <= '0;
         r_opnd   <= '0;
         r_sp     <= '0;
         r_passes <= '0;
         r_ovf    <= 1'b0;
         r_unf    <= 1'b0;
      end else begin
         r_addr   <= w_addr_nxt;
         r_opnd   <= w_opnd_nxt;
         r_sp     <= w_sp_nxt;
         r_passes <= w_passes_nxt;
         r_ovf    <= w_ovf_nxt;
         r_unf    <= w_unf_nxt;
      end
   end

   // Return stack storage; contents are don't-care after reset, so no reset term.
   always_ff @(posedge i_clk) begin
      if (!i_rst && w_push) begin
         r_stack[w_wr_idx] <= r_addr;
      end
   end

   assign o_addr   = r_addr;
   assign o_sp     = r_sp;
   assign o_passes = r_passes;
   assign o_ovf    = r_ovf;
   assign o_unf    = r_unf;
   assign o_halted = w_halted;

endmodule

// File: tb/tb_ue14500_sequencer.sv
// Bench for ue14500_sequencer: vector table for call/return/overflow/underflow/pass counting,
// plus hand sequences for address wrap, RUN freeze and FLF halt (UE14500_SEQ_FLF_HALT_EN aware).
// Inputs change #1 after posedge; outputs are checked at that same point.
module tb_ue14500_sequencer;

   localparam int ADDR_W = 8;
   localparam int SP_W   = 3;

   logic              clk;
   logic              i_rst, i_run, i_jmp, i_rtn, i_fl0, i_flf;
   logic [ADDR_W-1:0] i_target;
   logic [ADDR_W-1:0] o_addr;
   logic [SP_W-1:0]   o_sp;
   logic [7:0]        o_passes;
   logic              o_ovf, o_unf, o_halted;

   int n_cmp = 0;
   int n_err = 0;

   ue14500_sequencer #(.ADDR_W(ADDR_W), .STACK_DEPTH(4)) dut (
      .i_clk    (clk),
      .i_rst    (i_rst),
      .i_run    (i_run),
      .i_jmp    (i_jmp),
      .i_rtn    (i_rtn),
      .i_fl0    (i_fl0),
      .i_flf    (i_flf),
      .i_target (i_target),
      .o_addr   (o_addr),
      .o_sp     (o_sp),
      .o_passes (o_passes),
      .o_ovf    (o_ovf),
      .o_unf    (o_unf),
      .o_halted (o_halted)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic       rst, run, jmp, rtn, fl0;
      logic [7:0] target;
      logic [7:0] e_addr;
      int         e_sp;
      int         e_passes;
      logic       e_ovf, e_unf;
   } vec_t;

   vec_t vecs[$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic rst, input logic run, input logic jmp, input logic rtn,
                        input logic fl0, input logic flf, input logic [7:0] tgt);
      i_rst = rst; i_run = run; i_jmp = jmp; i_rtn = rtn;
      i_fl0 = fl0; i_flf = flf; i_target = tgt;
   endtask

   initial begin
      bit halt_en;
      logic [7:0] exp_a;
`ifdef UE14500_SEQ_FLF_HALT_EN
      halt_en = 1'b1;
`else
      halt_en = 1'b0;
`endif
      drive(1, 1, 0, 0, 0, 0, 8'h00);

      //                rst run jmp rtn fl0 target   addr  sp pas ovf unf
      vecs.push_back('{1, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0});
      vecs.push_back('{0, 1, 0, 0, 0, 8'h00, 8'h01, 0, 0, 0, 0});
      vecs.push_back('{0, 1, 0, 0, 0, 8'h00, 8'h02, 0, 0, 0, 0});
      vecs.push_back('{0, 1, 0, 0, 0, 8'h00, 8'h03, 0, 0, 0, 0});
      vecs.push_back('{0, 1, 0, 0, 0, 8'h00, 8'h04, 0, 0, 0, 0});
      vecs.push_back('{0, 1, 0, 0, 0, 8'h00, 8'h05, 0, 0, 0, 0});
      // word@5 carries 0x40; JMP arrives while ADDR=6
      vecs.push_back('{0, 1, 0, 0, 0, 8'h40, 8'h06, 0, 0, 0, 0});
      vecs.push_back('{0, 1, 1, 0, 0, 8'h11, 8'h40, 1, 0, 0, 0});
      vecs.push_back('{0, 1, 0, 0, 0, 8'h00, 8'h41, 1, 0, 0, 0});
      vecs.push_back('{0, 1, 0, 1, 0, 8'h00, 8'h06, 0, 0, 0, 0});
      vecs.push_back('{0, 1, 0, 0, 0, 8'h00, 8'h07, 0, 0, 0, 0});
      // JMP+RTN together on an empty stack: jump wins, no UNF; FL0 counts too
      vecs.push_back('{0, 1, 0, 0, 0, 8'h22, 8'h08, 0, 0, 0, 0});
      vecs.push_back('{0, 1, 1, 1, 1, 8'h00, 8'h22, 1, 1, 0, 0});
      vecs.push_back('{0, 1, 0, 1, 0, 8'h20, 8'h08, 0, 1, 0, 0});
      // five nested jumps: fifth overflows but is still taken
      vecs.push_back('{0, 1, 1, 0, 0, 8'h30, 8'h20, 1, 1, 0, 0});
      vecs.push_back('{0, 1, 1, 0, 0, 8'h50, 8'h30, 2, 1, 0, 0});
      vecs.push_back('{0, 1, 1, 0, 0, 8'h60, 8'h50, 3, 1, 0, 0});
      vecs.push_back('{0, 1, 1, 0, 0, 8'h70, 8'h60, 4, 1, 0, 0});
      vecs.push_back('{0, 1, 1, 0, 1, 8'h00, 8'h70, 4, 2, 1, 0});
      // unwind, then one pop too many
      vecs.push_back('{0, 1, 0, 1, 0, 8'h00, 8'h50, 3, 2, 1, 0});
      vecs.push_back('{0, 1, 0, 1, 0, 8'h00, 8'h30, 2, 2, 1, 0});
      vecs.push_back('{0, 1, 0, 1, 1, 8'h00, 8'h20, 1, 3, 1, 0});
      vecs.push_back('{0, 1, 0, 1, 0, 8'h00, 8'h08, 0, 3, 1, 0});
      vecs.push_back('{0, 1, 0, 1, 0, 8'h00, 8'h09, 0, 3, 1, 1});
      vecs.push_back('{0, 1, 0, 0, 0, 8'h00, 8'h0A, 0, 3, 1, 1});
      // reset clears sticky flags; reset mid-call empties the stack
      vecs.push_back('{1, 1, 0, 0, 0, 8'h44, 8'h00, 0, 0, 0, 0});
      vecs.push_back('{0, 1, 0, 0, 0, 8'h44, 8'h01, 0, 0, 0, 0});
      vecs.push_back('{0, 1, 1, 0, 0, 8'h00, 8'h44, 1, 0, 0, 0});
      vecs.push_back('{1, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0});
      vecs.push_back('{0, 1, 0, 1, 0, 8'h00, 8'h01, 0, 0, 0, 1});

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].rst, vecs[i].run, vecs[i].jmp, vecs[i].rtn, vecs[i].fl0, 0, vecs[i].target);
         tick();
         chk($sformatf("vec%0d_addr", i), int'(o_addr), int'(vecs[i].e_addr));
         chk($sformatf("vec%0d_sp", i), int'(o_sp), vecs[i].e_sp);
         chk($sformatf("vec%0d_passes", i), int'(o_passes), vecs[i].e_passes);
         chk($sformatf("vec%0d_ovf", i), int'(o_ovf), int'(vecs[i].e_ovf));
         chk($sformatf("vec%0d_unf", i), int'(o_unf), int'(vecs[i].e_unf));
         chk($sformatf("vec%0d_halted", i), int'(o_halted), 0);
      end

      // Free-running count with wrap past 0xFF
      drive(1, 1, 0, 0, 0, 0, 8'h00);
      tick();
      i_rst = 0;
      for (int i = 0; i < 260; i++) begin
         tick();
         chk($sformatf("count%0d_addr", i), int'(o_addr), (i + 1) % 256);
      end
      chk("count_sp", int'(o_sp), 0);
      chk("count_ovf", int'(o_ovf), 0);
      chk("count_unf", int'(o_unf), 0);

      // RUN=0 freeze with JMP and FL0 pulses dropped
      drive(1, 1, 0, 0, 0, 0, 8'h00);
      tick();
      i_rst = 0;
      tick();
      tick();
      i_target = 8'h55;
      tick();
      chk("frz_pre_addr", int'(o_addr), 3);
      drive(0, 0, 0, 0, 0, 0, 8'h66);
      for (int k = 0; k < 3; k++) begin
         i_jmp = (k == 1);
         i_fl0 = (k == 1);
         tick();
         chk($sformatf("frz%0d_addr", k), int'(o_addr), 3);
         chk($sformatf("frz%0d_sp", k), int'(o_sp), 0);
         chk($sformatf("frz%0d_passes", k), int'(o_passes), 0);
      end
      drive(0, 1, 0, 0, 0, 0, 8'h00);
      tick();
      chk("frz_resume_addr", int'(o_addr), 4);
      chk("frz_resume_sp", int'(o_sp), 0);

      // FLF at ADDR=0x10: halts only when the halt feature is built in
      drive(1, 1, 0, 0, 0, 0, 8'h00);
      tick();
      i_rst = 0;
      for (int k = 0; k < 16; k++) tick();
      chk("halt_pre_addr", int'(o_addr), 8'h10);
      i_flf = 1;
      tick();
      i_flf = 0;
      chk("halt_addr", int'(o_addr), 8'h11);
      chk("halt_flag", int'(o_halted), int'(halt_en));
      exp_a = 8'h11;
      for (int k = 0; k < 10; k++) begin
         i_fl0 = (k == 4);
         tick();
         if (!halt_en) exp_a = exp_a + 8'd1;
         chk($sformatf("halt%0d_addr", k), int'(o_addr), int'(exp_a));
      end
      i_fl0 = 0;
      chk("halt_passes", int'(o_passes), halt_en ? 0 : 1);
      i_run = 0;
      tick();
      i_run = 1;
      tick();
      chk("halt_runtoggle_flag", int'(o_halted), int'(halt_en));
      i_rst = 1;
      tick();
      i_rst = 0;
      chk("halt_rst_addr", int'(o_addr), 0);
      chk("halt_rst_flag", int'(o_halted), 0);
      tick();
      chk("halt_after_rst_addr", int'(o_addr), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
